// File: rtl/uart_rx_frame_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_frame_ctrl
//   Receive sequencer for a UART front end. It finds the start bit on the
//   synchronised line, times mid-bit sampling from the oversample tick, and
//   gates an external SIPO shift register. It also checks the stop bit and
//   holds each completed byte in an output register with a valid/ready
//   handshake.
//
//   Optional feature: define UART_RX_PARITY_EN to add an even-parity bit
//   between the data bits and the stop bit, plus the parity_err output.
//
// Parameters
//   DATA_BITS   data bits per frame (must match the SIPO width)
//   OVERSAMPLE  os_tick pulses per bit period (even, >= 4)
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high reset
//   os_tick      oversample enable, one clk wide, OVERSAMPLE per bit period
//   rx           raw serial line (synchronised internally, 2 flops)
//   sipo_data    parallel word from the SIPO
//   enable_sipo  high while receiving data bits
//   sipo_shift   one-clk strobe at each data-bit mid-point
//   rx_data      held received byte
//   rx_valid     rx_data valid, held until accepted
//   rx_ready     consumer ready
//   frame_err    one-clk pulse: stop bit sampled low
//   overrun_err  one-clk pulse: byte completed while previous one unaccepted
//   parity_err   (UART_RX_PARITY_EN only) one-clk pulse: parity mismatch
//   busy         high whenever the sequencer is not idle
//   fsm_state    current sequencer state, for observation
// ---------------------------------------------------------------------------
module uart_rx_frame_ctrl #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 os_tick,
  input  logic                 rx,
  input  logic [DATA_BITS-1:0] sipo_data,
  output logic                 enable_sipo,
  output logic                 sipo_shift,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy,
  output logic [2:0]           fsm_state
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t        state, state_next;
  logic [TW-1:0] tick_cnt, tick_next;
  logic [BW-1:0] bit_cnt, bit_next;
  logic          rx_meta, rx_s;
  logic          shift;
  logic          stop_eval;
`ifdef UART_RX_PARITY_EN
  logic          parity_bit;
  logic          parity_sample;
`endif

  // Two-flop synchroniser; both flops reset to the idle (high) line level
  // so a reset never looks like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
`ifdef UART_RX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      tick_cnt <= tick_next;
      bit_cnt  <= bit_next;
`ifdef UART_RX_PARITY_EN
      if (parity_sample) parity_bit <= rx_s;
`endif
    end
  end

  // Next-state and strobe logic. Counters only move on os_tick; a sample is
  // rx_s on the tick that completes the count.
  always_comb begin
    state_next = state;
    tick_next  = tick_cnt;
    bit_next   = bit_cnt;
    shift      = 1'b0;
    stop_eval  = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_sample = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        tick_next = '0;
        if (os_tick && !rx_s) state_next = S_START;
      end
      S_START: begin
        if (os_tick) begin
          if (tick_cnt == HALF_LAST) begin
            tick_next = '0;
            bit_next  = '0;
            // Line back high at mid-start: treat as a glitch, no error.
            state_next = rx_s ? S_IDLE : S_DATA;
          end else begin
            tick_next = tick_cnt + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (os_tick) begin
          if (tick_cnt == TICK_LAST) begin
            tick_next = '0;
            shift     = 1'b1;
            bit_next  = bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) begin
              bit_next = '0;
`ifdef UART_RX_PARITY_EN
              state_next = S_PARITY;
`else
              state_next = S_STOP;
`endif
            end
          end else begin
            tick_next = tick_cnt + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (os_tick) begin
          if (tick_cnt == TICK_LAST) begin
            tick_next     = '0;
            parity_sample = 1'b1;
            state_next    = S_STOP;
          end else begin
            tick_next = tick_cnt + 1'b1;
          end
        end
      end
`endif
      S_STOP: begin
        if (os_tick) begin
          if (tick_cnt == TICK_LAST) begin
            tick_next  = '0;
            stop_eval  = 1'b1;
            state_next = S_IDLE;
          end else begin
            tick_next = tick_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_next = S_IDLE;
        tick_next  = '0;
        bit_next   = '0;
      end
    endcase
  end

  // Output handshake: rx_valid rises the clk after a good stop bit and stays
  // high until a clk where rx_valid & rx_ready, after which it drops. If a
  // capture coincides with an accept, the new byte loads and rx_valid stays
  // high. A capture while the held byte is still unaccepted keeps the old
  // byte and pulses overrun_err instead.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err  <= 1'b0;
`endif
    end else begin
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err  <= 1'b0;
`endif
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (stop_eval) begin
`ifdef UART_RX_PARITY_EN
        // Even parity: the data bits plus the parity bit must hold an even
        // number of ones. The byte is delivered either way.
        parity_err <= (^sipo_data) ^ parity_bit;
`endif
        if (!rx_s) begin
          frame_err <= 1'b1;
        end else if (rx_valid && !rx_ready) begin
          overrun_err <= 1'b1;
        end else begin
          rx_data  <= sipo_data;
          rx_valid <= 1'b1;
        end
      end
    end
  end

  assign sipo_shift  = shift;
  assign enable_sipo = (state == S_DATA);
  assign busy        = (state != S_IDLE);
  assign fsm_state   = state;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_frame_ctrl
//   Directed bench for uart_rx_frame_ctrl (DATA_BITS=8, OVERSAMPLE=16).
//   A behavioural SIPO captures the raw line on each sipo_shift. Frames are
//   driven bit by bit, with 16 os_tick pulses per bit. Build with
//   UART_RX_PARITY_EN defined to exercise the parity variant.
// ---------------------------------------------------------------------------
module tb_uart_rx_frame_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       os_tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] sipo = '0;
  logic       enable_sipo, sipo_shift;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       frame_err, overrun_err, busy;
  logic [2:0] fsm_state;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  // Ticks from the last data strobe to the stop decision.
  localparam int STOP_WAIT   = (FRAME_BITS - 9) * 16;
  // Line released between the third break frame's start mid-point and its
  // first data mid-point.
  localparam int BREAK_TICKS = 2 * (9 + 16 * (FRAME_BITS - 1)) + 14;

  uart_rx_frame_ctrl #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .os_tick     (os_tick),
    .rx          (rx),
    .sipo_data   (sipo),
    .enable_sipo (enable_sipo),
    .sipo_shift  (sipo_shift),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
`ifdef UART_RX_PARITY_EN
    .parity_err  (parity_err),
`endif
    .busy        (busy),
    .fsm_state   (fsm_state)
  );

  // ---------------- clock / reset / tick ----------------
  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (3) @(posedge clk);
      #1 os_tick = 1'b1;
      @(posedge clk);
      #1 os_tick = 1'b0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Behavioural SIPO: LSB-first, samples the raw line at each strobe.
  always @(posedge clk or posedge reset) begin
    if (reset) sipo <= '0;
    else if (enable_sipo && sipo_shift) sipo <= {rx, sipo[7:1]};
  end

  // ---------------- monitors ----------------
  int tick_idx = 0, last_shift_tick = 0, frame_shifts = 0;
  int shift_total = 0, ferr_total = 0, ovr_total = 0, perr_total = 0;
  int spacing_bad = 0;

  always @(negedge clk) begin
    if (os_tick) tick_idx++;
    if (sipo_shift) begin
      if (!os_tick || !enable_sipo) spacing_bad++;
      if (frame_shifts != 0 && (tick_idx - last_shift_tick) != 16) spacing_bad++;
      last_shift_tick = tick_idx;
      frame_shifts++;
      shift_total++;
    end
    if (!busy) frame_shifts = 0;
    if (frame_err) ferr_total++;
    if (overrun_err) ovr_total++;
`ifdef UART_RX_PARITY_EN
    if (parity_err) perr_total++;
`endif
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(negedge clk);
      while (!os_tick) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop, input logic par);
    wait_ticks(1);
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      wait_ticks(16);
    end
`ifdef UART_RX_PARITY_EN
    rx = par;
    wait_ticks(16);
`else
    if (par) rx = 1'b1;
`endif
    rx = stop;
    wait_ticks(16);
    rx = 1'b1;
    wait_ticks(8);
  endtask

  task automatic wait_shifts(input int target, input string name);
    int n;
    n = 0;
    while (shift_total < target && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(shift_total >= target), 32'd1);
  endtask

  task automatic accept(input string name);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    @(negedge clk);
    check(name, rx_valid, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       par;
    logic       acc;
    logic       exp_valid;
    logic [7:0] exp_data;
    int         exp_ferr;
    int         exp_ovr;
    int         exp_perr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int s0, f0, o0, p0, b0;

    //            data   stop  par   acc   valid  data   ferr ovr perr
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 0, 0, 0};
    vecs[1] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1, 0, 0};
    vecs[2] = '{8'h11, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 0, 0, 0};
    vecs[3] = '{8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 0, 1, 0};
    vecs[4] = '{8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 0, 0, 0};
    vecs[5] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 8'hFF, 0, 0, 0};
    vecs[6] = '{8'h01, 1'b1, 1'b0, 1'b1, 1'b1, 8'h01, 0, 0, 1};
    vecs[7] = '{8'h07, 1'b1, 1'b1, 1'b1, 1'b1, 8'h07, 0, 0, 0};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_busy",     busy, 0);
    check("rst_valid",    rx_valid, 0);
    check("rst_data",     rx_data, 0);
    check("rst_ferr",     frame_err, 0);
    check("rst_ovr",      overrun_err, 0);
    check("rst_en",       enable_sipo, 0);
    check("rst_shift",    sipo_shift, 0);
    check("rst_state",    fsm_state, 0);
    reset = 1'b0;
    wait_ticks(4);
    check("idle_busy", busy, 0);

    // Table-driven frames.
    for (int i = 0; i < 8; i++) begin
      s0 = shift_total; f0 = ferr_total; o0 = ovr_total;
      p0 = perr_total;  b0 = spacing_bad;
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].par);
      wait_ticks(2);
      check($sformatf("v%0d_valid", i),   rx_valid, vecs[i].exp_valid);
      check($sformatf("v%0d_data", i),    rx_data, vecs[i].exp_data);
      check($sformatf("v%0d_shifts", i),  shift_total - s0, 8);
      check($sformatf("v%0d_spacing", i), spacing_bad - b0, 0);
      check($sformatf("v%0d_ferr", i),    ferr_total - f0, vecs[i].exp_ferr);
      check($sformatf("v%0d_ovr", i),     ovr_total - o0, vecs[i].exp_ovr);
      check($sformatf("v%0d_busy", i),    busy, 0);
`ifdef UART_RX_PARITY_EN
      check($sformatf("v%0d_perr", i),    perr_total - p0, vecs[i].exp_perr);
`endif
      if (vecs[i].acc) accept($sformatf("v%0d_accept", i));
    end

    // Accept in the same clk as a new capture: new byte, no overrun.
    send_frame(8'h11, 1'b1, 1'b0);
    wait_ticks(2);
    check("same_pre_data", rx_data, 8'h11);
    check("same_pre_valid", rx_valid, 1);
    s0 = shift_total; o0 = ovr_total;
    fork
      send_frame(8'h22, 1'b1, 1'b0);
      begin
        wait_shifts(s0 + 8, "same_wait");
        wait_ticks(STOP_WAIT);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
      end
    join
    wait_ticks(2);
    check("same_data",  rx_data, 8'h22);
    check("same_valid", rx_valid, 1);
    check("same_ovr",   ovr_total - o0, 0);
    accept("same_accept");

    // Start-bit glitch: low for 5 ticks only.
    s0 = shift_total; f0 = ferr_total;
    wait_ticks(1);
    rx = 1'b0;
    wait_ticks(5);
    check("glitch_busy_hi", busy, 1);
    rx = 1'b1;
    wait_ticks(12);
    check("glitch_busy_lo", busy, 0);
    check("glitch_shifts",  shift_total - s0, 0);
    check("glitch_ferr",    ferr_total - f0, 0);

    // Reset during DATA after 4 bits, then a clean frame.
    s0 = shift_total; f0 = ferr_total;
    fork
      send_frame(8'hF0, 1'b1, 1'b1);
      begin
        wait_shifts(s0 + 4, "mid_wait");
        reset = 1'b1;
        @(negedge clk);
        check("mid_busy", busy, 0);
        check("mid_en",   enable_sipo, 0);
        reset = 1'b0;
      end
    join
    wait_ticks(2);
    check("mid_ferr",  ferr_total - f0, 0);
    check("mid_valid", rx_valid, 0);
    check("mid_idle",  busy, 0);
    send_frame(8'h0F, 1'b1, 1'b0);
    wait_ticks(2);
    check("post_data",  rx_data, 8'h0F);
    check("post_valid", rx_valid, 1);
    accept("post_accept");

    // Break: two framing errors, then the frame in flight at release reads
    // the high line as 0xFF.
    s0 = shift_total; f0 = ferr_total; p0 = perr_total; b0 = spacing_bad;
    wait_ticks(1);
    rx = 1'b0;
    wait_ticks(BREAK_TICKS);
    rx = 1'b1;
    wait_ticks(200);
    check("brk_ferr",    ferr_total - f0, 2);
    check("brk_shifts",  shift_total - s0, 24);
    check("brk_spacing", spacing_bad - b0, 0);
    check("brk_valid",   rx_valid, 1);
    check("brk_data",    rx_data, 8'hFF);
    check("brk_busy",    busy, 0);
`ifdef UART_RX_PARITY_EN
    check("brk_perr",    perr_total - p0, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
